// File: rtl/uart_tx_fifo_if.sv
// Byte push channel into the UART transmit FIFO.
//   data  : byte to queue
//   valid : producer offers data this cycle
//   ready : FIFO can accept (not full)
// Handshake: a byte is taken on every rising clk edge where valid && ready.
// The producer must hold data stable while valid is high and ready is low;
// ready does not depend on valid.
interface uart_tx_fifo_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with an internal byte FIFO, single clock domain.
// Frame: start bit, 8 data bits LSB first, optional parity bit, one stop bit.
// Bit timing comes from tck_en, a one-cycle pulse per bit time.
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   tck_en            baud enable pulse
//   tx_enable         0 holds off new frames (a frame in flight completes)
//   tx_cts_n          peer clear-to-send, active-low, checked only at frame start
//   parity_en         insert parity bit (captured at frame start)
//   parity_odd        0 even / 1 odd parity (captured at frame start)
//   flush_tx          empties the FIFO, wins over a simultaneous push
//   txfifo            push channel (data/valid/ready)
//   txfifo_full/empty FIFO status
//   tx                registered serial line, idle high
//   tx_busy           FSM not idle
//   tx_done           one-cycle pulse as the stop bit ends
//   state_dbg         current FSM state encoding
module uart_tx_fifo #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           tck_en,
  input  logic           tx_enable,
  input  logic           tx_cts_n,
  input  logic           parity_en,
  input  logic           parity_odd,
  input  logic           flush_tx,
  uart_tx_fifo_if.slave  txfifo,
  output logic           txfifo_full,
  output logic           txfifo_empty,
  output logic           tx,
  output logic           tx_busy,
  output logic           tx_done,
  output logic [2:0]     state_dbg
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // ---------------- FIFO ----------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop;
  logic [7:0]    head;

  assign txfifo_full  = (count == (AW+1)'(FIFO_DEPTH));
  assign txfifo_empty = (count == '0);
  assign txfifo.ready = !txfifo_full;
  assign push         = txfifo.valid && txfifo.ready;
  assign head         = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push && !flush_tx) mem[wr_ptr] <= txfifo.data;
  end

  always_ff @(posedge clk) begin
    if (rst || flush_tx) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---------------- transmit FSM ----------------
  state_t     state_q, state_d;
  logic [7:0] sh_q, sh_d;
  logic [2:0] cnt_q, cnt_d;
  logic       par_q, par_d;
  logic       par_en_q, par_en_d;
  logic       tx_q, tx_d;
  logic       done_q, done_d;
  logic       start_ok;

  // Conditions for launching a frame; tck_en included so launch lines up with a bit boundary.
  assign start_ok = tck_en && !txfifo_empty && tx_enable && !tx_cts_n;

  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    cnt_d    = cnt_q;
    par_d    = par_q;
    par_en_d = par_en_q;
    tx_d     = tx_q;
    done_d   = 1'b0;
    pop      = 1'b0;

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (start_ok) begin
          pop      = 1'b1;
          sh_d     = head;
          par_d    = (^head) ^ parity_odd;
          par_en_d = parity_en;
          tx_d     = 1'b0;
          state_d  = S_START;
        end
      end
      S_START: begin
        if (tck_en) begin
          tx_d    = sh_q[0];
          cnt_d   = 3'd0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (tck_en) begin
          if (cnt_q == 3'd7) begin
            if (par_en_q) begin
              tx_d    = par_q;
              state_d = S_PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = S_STOP;
            end
          end else begin
            // Bit 1 of the current register becomes bit 0 after the shift.
            sh_d  = {1'b0, sh_q[7:1]};
            tx_d  = sh_q[1];
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (tck_en) begin
          tx_d    = 1'b1;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (tck_en) begin
          done_d = 1'b1;
          if (start_ok) begin
            // Back-to-back frame: start bit follows the stop bit directly.
            pop      = 1'b1;
            sh_d     = head;
            par_d    = (^head) ^ parity_odd;
            par_en_d = parity_en;
            tx_d     = 1'b0;
            state_d  = S_START;
          end else begin
            tx_d    = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sh_q     <= '0;
      cnt_q    <= '0;
      par_q    <= 1'b0;
      par_en_q <= 1'b0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sh_q     <= sh_d;
      cnt_q    <= cnt_d;
      par_q    <= par_d;
      par_en_q <= par_en_d;
      tx_q     <= tx_d;
      done_q   <= done_d;
    end
  end

  assign tx        = tx_q;
  assign tx_done   = done_q;
  assign tx_busy   = (state_q != S_IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a line monitor decodes frames at each baud tick and
// compares them against an expected-frame queue filled when bytes are pushed.
module tb_uart_tx_fifo;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       tck_en = 1'b0;
  logic       tx_enable, tx_cts_n, parity_en, parity_odd, flush_tx;
  logic       txfifo_full, txfifo_empty, tx, tx_busy, tx_done;
  logic [2:0] state_dbg;

  uart_tx_fifo_if txfifo_bus ();

  uart_tx_fifo #(.FIFO_DEPTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .tck_en       (tck_en),
    .tx_enable    (tx_enable),
    .tx_cts_n     (tx_cts_n),
    .parity_en    (parity_en),
    .parity_odd   (parity_odd),
    .flush_tx     (flush_tx),
    .txfifo       (txfifo_bus.slave),
    .txfifo_full  (txfifo_full),
    .txfifo_empty (txfifo_empty),
    .tx           (tx),
    .tx_busy      (tx_busy),
    .tx_done      (tx_done),
    .state_dbg    (state_dbg)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- baud tick generator ----------------
  int tck_div = 4;
  int tck_cnt = 0;
  always @(posedge clk) begin
    #1;
    if (tck_cnt >= tck_div - 1) begin
      tck_cnt = 0;
      tck_en  = 1'b1;
    end else begin
      tck_cnt++;
      tck_en = 1'b0;
    end
  end

  // ---------------- scoreboard / line monitor ----------------
  // Expected frame entry: {parity_en, parity_bit, data}
  logic [9:0]  exp_q[$];
  logic [9:0]  cur;
  int          m_state = 0;
  int          bit_i = 0;
  int          frame_bits = 0;
  int          last_frame_bits = 0;
  int          done_cnt = 0;
  int          idle_cnt = 0;
  int          gap_sum = 0;
  int          glitch_errs = 0;
  bit          prev_ended = 1'b0;
  logic [7:0]  rx_byte;
  logic [10:0] frame_vec, last_frame_vec;
  logic        last_tx = 1'b1;

  always @(posedge clk) begin
    logic hit, r;
    hit = tck_en;
    r   = rst;
    #2;
    if (tx_done === 1'b1) done_cnt++;
    if (r) begin
      m_state = 0;
      bit_i   = 0;
    end else if (hit) begin
      case (m_state)
        0: begin
          if (tx === 1'b0) begin
            if (exp_q.size() == 0) begin
              tests++;
              fails++;
              $display("FAIL unexpected_frame: start bit seen with no byte queued at %0t", $time);
              cur = '0;
            end else begin
              cur = exp_q.pop_front();
            end
            if (prev_ended) gap_sum += idle_cnt;
            idle_cnt   = 0;
            m_state    = 1;
            bit_i      = 0;
            frame_bits = 1;
            rx_byte    = '0;
            frame_vec  = '0;
          end else begin
            idle_cnt++;
          end
        end
        1: begin
          rx_byte[bit_i] = tx;
          frame_vec = {frame_vec[9:0], tx};
          bit_i++;
          frame_bits++;
          if (bit_i == 8) m_state = cur[9] ? 2 : 3;
        end
        2: begin
          frame_vec = {frame_vec[9:0], tx};
          frame_bits++;
          check("parity_bit", 32'(tx), 32'(cur[8]));
          m_state = 3;
        end
        default: begin
          frame_vec = {frame_vec[9:0], tx};
          frame_bits++;
          check("stop_bit", 32'(tx), 32'd1);
          check("rx_data", 32'(rx_byte), 32'(cur[7:0]));
          last_frame_bits = frame_bits;
          last_frame_vec  = frame_vec;
          prev_ended = 1'b1;
          idle_cnt   = 0;
          m_state    = 0;
        end
      endcase
    end else if (tx !== last_tx) begin
      glitch_errs++;
    end
    last_tx = tx;
  end

  // ---------------- driver tasks ----------------
  // Leaves valid high so consecutive calls push on consecutive cycles.
  task automatic push_byte(input logic [7:0] d, output bit acc);
    @(negedge clk);
    acc = txfifo_bus.ready;
    txfifo_bus.data  = d;
    txfifo_bus.valid = 1'b1;
    if (acc) exp_q.push_back({parity_en, (^d) ^ parity_odd, d});
  endtask

  task automatic end_push();
    @(negedge clk);
    txfifo_bus.valid = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(done_cnt), 32'(target));
  endtask

  task automatic wait_bit(input int b, input int budget, input string name);
    int n = 0;
    while (!(m_state == 1 && bit_i == b) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(n < budget), 32'd1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0]  data;
    logic        pe;
    logic        po;
    logic        exp_par;
    int          div;
    int          exp_len;
    logic        chk_vec;
    logic [10:0] exp_vec;
  } vec_t;

  vec_t vecs[8];

  initial begin
    bit acc;
    int d0;
    int n_acc;
    bit acc9;

    vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 4, 10, 1'b1, 11'b00101001011};
    vecs[1] = '{8'h03, 1'b1, 1'b0, 1'b0, 4, 11, 1'b0, 11'd0};
    vecs[2] = '{8'h03, 1'b1, 1'b1, 1'b1, 4, 11, 1'b0, 11'd0};
    vecs[3] = '{8'hFF, 1'b1, 1'b0, 1'b0, 3, 11, 1'b0, 11'd0};
    vecs[4] = '{8'h80, 1'b1, 1'b0, 1'b1, 1, 11, 1'b0, 11'd0};
    vecs[5] = '{8'h00, 1'b1, 1'b1, 1'b1, 2, 11, 1'b0, 11'd0};
    vecs[6] = '{8'h5A, 1'b0, 1'b1, 1'b0, 1, 10, 1'b0, 11'd0};
    vecs[7] = '{8'h7E, 1'b1, 1'b1, 1'b1, 5, 11, 1'b0, 11'd0};

    rst = 1'b1;
    tx_enable = 1'b1;
    tx_cts_n  = 1'b0;
    parity_en = 1'b0;
    parity_odd = 1'b0;
    flush_tx  = 1'b0;
    txfifo_bus.data  = '0;
    txfifo_bus.valid = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_done", 32'(tx_done), 32'd0);
    check("rst_empty", 32'(txfifo_empty), 32'd1);
    check("rst_full", 32'(txfifo_full), 32'd0);
    check("rst_ready", 32'(txfifo_bus.ready), 32'd1);
    check("rst_state", 32'(state_dbg), 32'd0);
    rst = 1'b0;

    // Single frames from the table; config is flipped mid-frame and must not leak in.
    for (int i = 0; i < 8; i++) begin
      tck_div    = vecs[i].div;
      parity_en  = vecs[i].pe;
      parity_odd = vecs[i].po;
      d0 = done_cnt;
      @(negedge clk);
      acc = 1'b0;
      txfifo_bus.data  = vecs[i].data;
      txfifo_bus.valid = 1'b1;
      exp_q.push_back({vecs[i].pe, vecs[i].exp_par, vecs[i].data});
      end_push();
      repeat (6) @(negedge clk);
      parity_en  = ~parity_en;
      parity_odd = ~parity_odd;
      wait_done(d0 + 1, 14 * vecs[i].div + 20, "table_done");
      check("table_busy_after", 32'(tx_busy), 32'd0);
      check("table_len", 32'(last_frame_bits), 32'(vecs[i].exp_len));
      if (vecs[i].chk_vec) check("table_bits", 32'(last_frame_vec), 32'(vecs[i].exp_vec));
      repeat (2 * vecs[i].div + 2) @(negedge clk);
      check("table_single_done", 32'(done_cnt), 32'(d0 + 1));
    end

    // FIFO fill with flow control held off, then back-to-back drain.
    tck_div = 4;
    parity_en = 1'b0;
    parity_odd = 1'b0;
    tx_cts_n = 1'b1;
    n_acc = 0;
    acc9 = 1'b1;
    for (int i = 0; i < 9; i++) begin
      push_byte(8'(8'h11 * i + 8'h21), acc);
      if (i < 8) n_acc += int'(acc);
      else acc9 = acc;
    end
    end_push();
    check("fill_full", 32'(txfifo_full), 32'd1);
    check("fill_accepted", 32'(n_acc), 32'd8);
    check("fill_ninth_refused", 32'(acc9), 32'd0);
    check("fill_idle_line", 32'(tx), 32'd1);
    gap_sum = 0;
    prev_ended = 1'b0;
    d0 = done_cnt;
    tx_cts_n = 1'b0;
    wait_done(d0 + 8, 8 * 11 * 4 + 60, "drain_done");
    check("drain_gap", 32'(gap_sum), 32'd0);
    check("drain_empty", 32'(txfifo_empty), 32'd1);
    repeat (10) @(negedge clk);
    check("drain_busy", 32'(tx_busy), 32'd0);

    // tx_enable gating
    tx_enable = 1'b0;
    d0 = done_cnt;
    push_byte(8'h4C, acc);
    push_byte(8'hB3, acc);
    end_push();
    repeat (40) @(negedge clk);
    check("gate_tx_high", 32'(tx), 32'd1);
    check("gate_busy", 32'(tx_busy), 32'd0);
    check("gate_not_empty", 32'(txfifo_empty), 32'd0);
    check("gate_no_done", 32'(done_cnt), 32'(d0));
    tx_enable = 1'b1;
    begin
      logic h;
      int n;
      h = 1'b0;
      n = 0;
      while (!h && n < 20) begin
        @(posedge clk);
        h = tck_en;
        @(negedge clk);
        n++;
      end
    end
    check("gate_start_tx", 32'(tx), 32'd0);
    check("gate_start_busy", 32'(tx_busy), 32'd1);
    wait_done(d0 + 2, 2 * 11 * 4 + 40, "gate_done");

    // Flush during frame 1 with a push in the same cycle
    repeat (10) @(negedge clk);
    tx_enable = 1'b0;
    d0 = done_cnt;
    push_byte(8'hE1, acc);
    push_byte(8'h17, acc);
    push_byte(8'h6D, acc);
    end_push();
    tx_enable = 1'b1;
    wait_bit(3, 200, "flush_reach_bit3");
    @(negedge clk);
    flush_tx = 1'b1;
    txfifo_bus.data  = 8'h99;
    txfifo_bus.valid = 1'b1;
    @(negedge clk);
    flush_tx = 1'b0;
    txfifo_bus.valid = 1'b0;
    while (exp_q.size() > 0) void'(exp_q.pop_back());
    check("flush_empty", 32'(txfifo_empty), 32'd1);
    wait_done(d0 + 1, 11 * 4 + 40, "flush_frame_done");
    repeat (60) @(negedge clk);
    check("flush_no_more", 32'(done_cnt), 32'(d0 + 1));
    check("flush_idle", 32'(tx_busy), 32'd0);

    // Reset in the middle of data bits
    push_byte(8'hC3, acc);
    push_byte(8'h55, acc);
    end_push();
    wait_bit(4, 200, "rst_reach_bit4");
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("midrst_tx", 32'(tx), 32'd1);
    check("midrst_busy", 32'(tx_busy), 32'd0);
    check("midrst_empty", 32'(txfifo_empty), 32'd1);
    rst = 1'b0;
    parity_en = 1'b1;
    parity_odd = 1'b1;
    d0 = done_cnt;
    push_byte(8'h3C, acc);
    end_push();
    wait_bit(2, 200, "post_rst_start");
    tx_cts_n = 1'b1;
    wait_done(d0 + 1, 11 * 4 + 40, "post_rst_done");
    check("post_rst_len", 32'(last_frame_bits), 32'd11);
    tx_cts_n = 1'b0;
    repeat (10) @(negedge clk);

    check("no_glitch", 32'(glitch_errs), 32'd0);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    fails++;
    $display("FAIL timeout: simulation did not complete");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end

endmodule
